bb_dffrs_wr_arbiter: RTL and testbench

- Shares one DW-bit set/reset-capable state register between NREQ requesters.
- Each cycle, a rotating-priority arbiter grants one requester, which may load, set, clear or hold the register.
- A requester can lock the register for a bounded burst of consecutive grants.
- Sits in front of status/control flops written by several agents; holds the register internally.

---
 rtl/bb_arb_pkg.sv | 16 +
 rtl/bb_rr_pick.sv | 38 +++
 rtl/bb_dffrs_wr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bb_dffrs_wr_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bb_arb_pkg.sv
// Shared definitions for the write-arbitrated set/reset register.
//   - Per-requester opcode encodings (2 bits each).
//   - Arbiter FSM state type.
package bb_arb_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/bb_rr_pick.sv
// Combinational rotating-priority picker.
//   req  in  NREQ  request vector
//   ptr  in  IW    index with highest priority this cycle
//   gnt  out NREQ  one-hot grant (zero when no request)
//   idx  out IW    index of the granted requester (0 when none)
//   vld  out 1     a grant was made
module bb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  int w_c;

  // Walk ptr, ptr+1, ... with an explicit wrap so non-power-of-2 NREQ
  // never produces an out-of-range index.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    w_c = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_c = int'(ptr) + k;
      if (w_c >= NREQ) w_c = w_c - NREQ;
      if (!vld && req[w_c]) begin
        vld      = 1'b1;
        idx      = IW'(w_c);
        gnt[w_c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bb_dffrs_wr_arbiter.sv
// One DW-bit set/reset-capable register shared by NREQ writers.
// A rotating-priority arbiter grants one requester per cycle; the granted
// requester loads, sets, clears or holds the register. A requester may lock
// the register for a burst of up to MAX_HOLD consecutive grants.
//   clk        in  1        clock
//   rst        in  1        synchronous active-high reset
//   req        in  NREQ     per-requester request
//   lock       in  NREQ     per-requester burst request (with req)
//   op         in  2*NREQ   per-requester opcode
//   wdata      in  DW*NREQ  per-requester load data
//   gnt        out NREQ     combinational one-hot/zero grant
//   dout       out DW       register value
//   upd        out 1        pulse the cycle after a register write
//   owner_vld  out 1        lock is held
//   owner      out IW       lock owner index (0 when unlocked)
module bb_dffrs_wr_arbiter
  import bb_arb_pkg::*;
#(
  parameter int             NREQ     = 4,
  parameter int             DW       = 8,
  parameter logic [DW-1:0]  RST_VAL  = '0,
  parameter logic [DW-1:0]  SET_VAL  = '1,
  parameter int             MAX_HOLD = 4,
  localparam int            IW       = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [2*NREQ-1:0]    op,
  input  logic [DW*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        dout,
  output logic                 upd,
  output logic                 owner_vld,
  output logic [IW-1:0]        owner
);

  arb_state_t      r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [7:0]      r_hold, w_hold_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic            r_owner_vld, w_owner_vld_nxt;
  logic [DW-1:0]   r_dout;
  logic            r_upd;

  logic [NREQ-1:0] w_pick_gnt;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_vld;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_g;
  logic            w_gv;
  logic [1:0]      w_op;
  logic [DW-1:0]   w_wd;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
    if (i == IW'(NREQ - 1)) return '0;
    return i + IW'(1);
  endfunction

  bb_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .vld (w_pick_vld)
  );

  // Grant: round-robin pick in IDLE, owner-only while LOCKED, none in reset.
  always_comb begin
    w_gnt = '0;
    w_g   = '0;
    w_gv  = 1'b0;
    if (!rst) begin
      if (r_state == IDLE) begin
        w_gnt = w_pick_gnt;
        w_g   = w_pick_idx;
        w_gv  = w_pick_vld;
      end else if (req[r_owner]) begin
        w_gnt[r_owner] = 1'b1;
        w_g            = r_owner;
        w_gv           = 1'b1;
      end
    end
  end

  assign w_op = op[2*int'(w_g) +: 2];
  assign w_wd = wdata[DW*int'(w_g) +: DW];

  // Next-state: lock entry, burst cap, release and abandonment.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_hold_nxt      = r_hold;
    w_owner_nxt     = r_owner;
    w_owner_vld_nxt = r_owner_vld;
    unique case (r_state)
      IDLE: begin
        if (w_gv) begin
          if (lock[w_g] && (MAX_HOLD > 1)) begin
            w_state_nxt     = LOCKED;
            w_owner_nxt     = w_g;
            w_owner_vld_nxt = 1'b1;
            w_hold_nxt      = 8'd1;
          end else begin
            w_ptr_nxt = inc_wrap(w_g);
          end
        end
      end
      LOCKED: begin
        // Stay only while the owner keeps both req and lock and the cap
        // has not been reached; every other path hands priority onward.
        if (req[r_owner] && lock[r_owner] && ((int'(r_hold) + 1) < MAX_HOLD)) begin
          w_hold_nxt = r_hold + 8'd1;
        end else begin
          w_state_nxt     = IDLE;
          w_ptr_nxt       = inc_wrap(r_owner);
          w_hold_nxt      = 8'd0;
          w_owner_nxt     = '0;
          w_owner_vld_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold      <= 8'd0;
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold      <= w_hold_nxt;
      r_owner     <= w_owner_nxt;
      r_owner_vld <= w_owner_vld_nxt;
    end
  end

  // Register write: one write per cycle from the granted requester only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= RST_VAL;
      r_upd  <= 1'b0;
    end else if (w_gv) begin
      unique case (w_op)
        OP_LOAD:  r_dout <= w_wd;
        OP_SET:   r_dout <= SET_VAL;
        OP_CLEAR: r_dout <= RST_VAL;
        default:  r_dout <= r_dout;
      endcase
      r_upd <= (w_op != OP_NOP);
    end else begin
      r_upd <= 1'b0;
    end
  end

  assign gnt       = w_gnt;
  assign dout      = r_dout;
  assign upd       = r_upd;
  assign owner_vld = r_owner_vld;
  assign owner     = r_owner;

endmodule

// File: tb/tb_bb_dffrs_wr_arbiter.sv
// Directed bench for bb_dffrs_wr_arbiter (NREQ=4, DW=8, MAX_HOLD=4).
module tb_bb_dffrs_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [7:0]  op;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  dout;
  logic        upd;
  logic        owner_vld;
  logic [1:0]  owner;

  int n_total = 0;
  int n_pass  = 0;

  bb_dffrs_wr_arbiter #(
    .NREQ(4), .DW(8), .RST_VAL(8'h00), .SET_VAL(8'hFF), .MAX_HOLD(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .op(op), .wdata(wdata),
    .gnt(gnt), .dout(dout), .upd(upd), .owner_vld(owner_vld), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [1:0] v);
    op[2*i +: 2] = v;
  endtask

  task automatic set_wd(input int i, input logic [7:0] v);
    wdata[8*i +: 8] = v;
  endtask

  initial begin
    // Reset with all requesters active
    rst = 1'b1; req = 4'b1111; lock = 4'b0000; op = 8'h00;
    for (int i = 0; i < 4; i++) set_wd(i, 8'h10 + 8'(i));
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    tick(); tick();
    chk("rst_gnt2", gnt, 4'b0000);
    chk("rst_dout", dout, 8'h00);
    chk("rst_upd", upd, 1'b0);
    chk("rst_ovld", owner_vld, 1'b0);
    chk("rst_owner", owner, 2'd0);

    // Round-robin: all LOAD, no lock
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_gnt", gnt, 4'b0001 << (c % 4));
      tick();
      chk("rr_dout", dout, 8'h10 + 8'(c % 4));
      chk("rr_upd", upd, 1'b1);
    end

    // Single requester 2: SET, CLEAR, LOAD 5A, NOP
    req = 4'b0100;
    set_wd(2, 8'h5A);
    set_op(2, 2'b01); #1; chk("op_set_gnt", gnt, 4'b0100);
    tick(); chk("op_set_dout", dout, 8'hFF); chk("op_set_upd", upd, 1'b1);
    set_op(2, 2'b10); #1; chk("op_clr_gnt", gnt, 4'b0100);
    tick(); chk("op_clr_dout", dout, 8'h00); chk("op_clr_upd", upd, 1'b1);
    set_op(2, 2'b00); #1; chk("op_ld_gnt", gnt, 4'b0100);
    tick(); chk("op_ld_dout", dout, 8'h5A); chk("op_ld_upd", upd, 1'b1);
    set_op(2, 2'b11); #1; chk("op_nop_gnt", gnt, 4'b0100);
    tick(); chk("op_nop_dout", dout, 8'h5A); chk("op_nop_upd", upd, 1'b0);

    // Move pointer to 1 with a NOP grant to requester 0 (ptr was 3)
    req = 4'b0001; op = 8'hFF;
    #1; chk("prep_gnt", gnt, 4'b0001);
    tick(); chk("prep_upd", upd, 1'b0);

    // Lock cap: requester 1 holds lock, exactly 4 grants
    req = 4'b1111; lock = 4'b0010; op = 8'h00;
    for (int i = 0; i < 4; i++) set_wd(i, 8'h10 + 8'(i));
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("cap_gnt", gnt, 4'b0010);
      tick();
      chk("cap_dout", dout, 8'h11);
      chk("cap_ovld", owner_vld, (c < 3) ? 1'b1 : 1'b0);
      chk("cap_owner", owner, (c < 3) ? 2'd1 : 2'd0);
    end
    #1; chk("cap_next_gnt", gnt, 4'b0100);
    tick(); chk("cap_next_dout", dout, 8'h12);

    // Abandon: owner 3 locks, 2 grants, then drops req
    lock = 4'b1000;
    #1; chk("ab_gnt1", gnt, 4'b1000);
    tick(); chk("ab_ovld1", owner_vld, 1'b1); chk("ab_owner1", owner, 2'd3);
    #1; chk("ab_gnt2", gnt, 4'b1000);
    tick(); chk("ab_dout2", dout, 8'h13);
    req = 4'b0111;
    #1; chk("ab_gnt_none", gnt, 4'b0000);
    tick();
    chk("ab_upd", upd, 1'b0);
    chk("ab_dout", dout, 8'h13);
    chk("ab_ovld", owner_vld, 1'b0);
    req = 4'b1111; lock = 4'b0000;
    #1; chk("ab_wrap_gnt", gnt, 4'b0001);
    tick(); chk("ab_wrap_dout", dout, 8'h10);

    // Reset mid-burst: requester 2 owns the lock (grant 1 first, ptr -> 2)
    #1; chk("mb_pre_gnt", gnt, 4'b0010);
    tick();
    lock = 4'b0100;
    #1; chk("mb_lock_gnt", gnt, 4'b0100);
    tick();
    chk("mb_ovld", owner_vld, 1'b1);
    chk("mb_owner", owner, 2'd2);
    chk("mb_dout", dout, 8'h12);
    rst = 1'b1; set_wd(2, 8'h77);
    #1; chk("mb_rst_gnt", gnt, 4'b0000);
    tick();
    chk("mb_rst_dout", dout, 8'h00);
    chk("mb_rst_ovld", owner_vld, 1'b0);
    chk("mb_rst_owner", owner, 2'd0);
    chk("mb_rst_upd", upd, 1'b0);
    rst = 1'b0; lock = 4'b0000; op = 8'hFF;
    #1; chk("mb_ptr0_gnt", gnt, 4'b0001);
    tick();
    chk("mb_no77_dout", dout, 8'h00);
    chk("mb_no77_upd", upd, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
